// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM states, parity selectors, defaults.
// Macro UART_RX_SYNC_EN (see uart_rx_frame) adds an RX_IN synchronizer.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int OVERSAMPLE_DEF = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   function automatic logic maj3(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: edge/bit counters and 3-sample mid-bit majority vote.
// Ports: i_clk, i_rst_n, i_en (frame active), i_rx -> o_bit_cnt,
// o_sample, o_sample_done (edge = OS/2+1), o_bit_done (edge wrap).
module uart_rx_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_rx,
   output logic [BIT_CNT_W-1:0] o_bit_cnt,
   output logic                 o_sample,
   output logic                 o_sample_done,
   output logic                 o_bit_done
);

   localparam int EW = $clog2(OVERSAMPLE);

   localparam logic [EW-1:0] E_S0   = EW'(OVERSAMPLE / 2 - 1);
   localparam logic [EW-1:0] E_S1   = EW'(OVERSAMPLE / 2);
   localparam logic [EW-1:0] E_S2   = EW'(OVERSAMPLE / 2 + 1);
   localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);

   logic [EW-1:0]        r_edge_cnt;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic                 r_s0;
   logic                 r_s1;

   // Counters sit at zero while idle, so a start edge begins at edge 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
      end else if (!i_en) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else begin
         if (r_edge_cnt == E_LAST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
         end else begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
         end
         if (r_edge_cnt == E_S0) r_s0 <= i_rx;
         if (r_edge_cnt == E_S1) r_s1 <= i_rx;
      end
   end

   // Third sample is the live line; the FSM registers the vote.
   assign o_sample      = maj3(r_s0, r_s1, i_rx);
   assign o_sample_done = i_en && (r_edge_cnt == E_S2);
   assign o_bit_done    = i_en && (r_edge_cnt == E_LAST);
   assign o_bit_cnt     = r_bit_cnt;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start, DATA_WIDTH bits LSB first, opt parity, 1 stop.
// Ports: CLK, RST (async low), RX_IN, PAR_EN, PAR_TYP -> P_DATA,
// DATA_VALID, PAR_ERR, STP_ERR. Macro UART_RX_SYNC_EN: 2-flop RX sync.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int BCW = $clog2(DATA_WIDTH + 3);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH);

   logic w_rx;

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_rx_sync;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_rx_sync <= 2'b11;
      else      r_rx_sync <= {r_rx_sync[0], RX_IN};
   end

   assign w_rx = r_rx_sync[1];
`else
   assign w_rx = RX_IN;
`endif

   state_t                r_state;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_par_fail;
   logic [DATA_WIDTH-1:0] r_shift;

   logic           w_en;
   logic [BCW-1:0] w_bit_cnt;
   logic           w_sample;
   logic           w_sample_done;
   logic           w_bit_done;
   logic           w_exp_par;

   assign w_en      = (r_state != IDLE);
   assign w_exp_par = (^r_shift) ^ (r_par_typ == PAR_ODD);

   uart_rx_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE),
      .BIT_CNT_W  (BCW)
   ) u_timer (
      .i_clk         (CLK),
      .i_rst_n       (RST),
      .i_en          (w_en),
      .i_rx          (w_rx),
      .o_bit_cnt     (w_bit_cnt),
      .o_sample      (w_sample),
      .o_sample_done (w_sample_done),
      .o_bit_done    (w_bit_done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_par_en   <= 1'b0;
         r_par_typ  <= PAR_EVEN;
         r_par_fail <= 1'b0;
         r_shift    <= '0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (!w_rx) begin
                  r_state    <= START;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  r_par_fail <= 1'b0;
               end
            end
            START: begin
               // A start that votes high at mid-bit was a glitch.
               if (w_sample_done && w_sample)
                  r_state <= IDLE;
               else if (w_bit_done)
                  r_state <= DATA;
            end
            DATA: begin
               if (w_sample_done)
                  r_shift <= {w_sample, r_shift[DATA_WIDTH-1:1]};
               if (w_bit_done && (w_bit_cnt == LAST_BIT))
                  r_state <= r_par_en ? PARITY : STOP;
            end
            PARITY: begin
               if (w_sample_done && (w_sample != w_exp_par))
                  r_par_fail <= 1'b1;
               if (w_bit_done)
                  r_state <= STOP;
            end
            STOP: begin
               // Decide at mid-stop so a following start is not missed.
               if (w_sample_done) begin
                  r_state <= IDLE;
                  STP_ERR <= !w_sample;
                  PAR_ERR <= r_par_fail;
                  if (w_sample && !r_par_fail) begin
                     P_DATA     <= r_shift;
                     DATA_VALID <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: framing, parity, stop, glitch,
// noise, reset abort, back-to-back frames and line break.
module tb_uart_rx_frame;
   import uart_pkg::*;

   localparam int DW = 8;
   localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
   localparam int LAT_ADD = 2;
`else
   localparam int LAT_ADD = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx = 1'b1;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [DW-1:0] p_data;
   logic          dv;
   logic          pe;
   logic          se;

   uart_rx_frame #(
      .DATA_WIDTH (DW),
      .OVERSAMPLE (OS)
   ) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .RX_IN      (rx),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .P_DATA     (p_data),
      .DATA_VALID (dv),
      .PAR_ERR    (pe),
      .STP_ERR    (se)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int        n_dv = 0;
   int        n_pe = 0;
   int        n_se = 0;
   int        n_mix = 0;
   int        n_long = 0;
   int        dv_cyc = 0;
   logic      dv_q = 1'b0;
   logic [7:0] dv_log[$];

   always @(negedge clk) begin
      if (dv) begin
         n_dv = n_dv + 1;
         dv_cyc = cyc;
         dv_log.push_back(p_data);
         if (dv_q) n_long = n_long + 1;
      end
      if (pe) n_pe = n_pe + 1;
      if (se) n_se = n_se + 1;
      if (dv && (pe || se)) n_mix = n_mix + 1;
      dv_q = dv;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int b_dv = 0;
   int b_pe = 0;
   int b_se = 0;

   task automatic snap();
      b_dv = n_dv;
      b_pe = n_pe;
      b_se = n_se;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_drv(input logic b, input int nidx);
      for (int s = 0; s < OS; s++) begin
         rx = (s == nidx) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send(
      input logic [7:0] d,
      input logic       pen,
      input logic       pbit,
      input logic       stp,
      input int         nidx,
      input logic       flip
   );
      bit_drv(1'b0, -1);
      if (flip) begin
         par_en  = ~par_en;
         par_typ = ~par_typ;
      end
      for (int i = 0; i < DW; i++) bit_drv(d[i], nidx);
      if (pen) bit_drv(pbit, -1);
      bit_drv(stp, -1);
   endtask

   int         st;
   logic [31:0] f0;
   logic [31:0] f1;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_data", 32'(p_data), 32'h0);
      check("rst_dv", 32'(dv), 32'h0);
      check("rst_pe", 32'(pe), 32'h0);
      check("rst_se", 32'(se), 32'h0);
      rst_n = 1'b1;
      idle(5);

      par_en = 1'b0;
      snap();
      st = cyc + 1;
      send(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      check("basic_dv", n_dv - b_dv, 1);
      check("basic_data", 32'(p_data), 32'hA5);
      check("basic_pe", n_pe - b_pe, 0);
      check("basic_se", n_se - b_se, 0);
      check("basic_lat", dv_cyc - st, 78 + LAT_ADD);

      par_en = 1'b1;
      par_typ = PAR_EVEN;
      snap();
      send(8'h3C, 1'b1, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      check("even_dv", n_dv - b_dv, 1);
      check("even_data", 32'(p_data), 32'h3C);
      check("even_pe", n_pe - b_pe, 0);

      snap();
      send(8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b0);
      idle(4);
      check("perr_pe", n_pe - b_pe, 1);
      check("perr_dv", n_dv - b_dv, 0);
      check("perr_se", n_se - b_se, 0);
      check("perr_data", 32'(p_data), 32'h3C);

      snap();
      send(8'h3D, 1'b1, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      check("perr2_pe", n_pe - b_pe, 1);
      check("perr2_dv", n_dv - b_dv, 0);
      check("perr2_data", 32'(p_data), 32'h3C);

      par_en = 1'b1;
      par_typ = PAR_EVEN;
      snap();
      send(8'h81, 1'b1, 1'b0, 1'b1, -1, 1'b1);
      idle(4);
      check("flip_dv", n_dv - b_dv, 1);
      check("flip_data", 32'(p_data), 32'h81);
      check("flip_pe", n_pe - b_pe, 0);
      check("flip_se", n_se - b_se, 0);

      par_en = 1'b1;
      par_typ = PAR_ODD;
      snap();
      send(8'h01, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      idle(20);
      check("stop_se", n_se - b_se, 1);
      check("stop_pe", n_pe - b_pe, 0);
      check("stop_dv", n_dv - b_dv, 0);
      check("stop_data", 32'(p_data), 32'h81);

      par_en = 1'b0;
      snap();
      rx = 1'b0;
      repeat (2) @(negedge clk);
      idle(20);
      check("glitch_dv", n_dv - b_dv, 0);
      check("glitch_pe", n_pe - b_pe, 0);
      check("glitch_se", n_se - b_se, 0);
      snap();
      send(8'h5A, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      check("glitch2_dv", n_dv - b_dv, 1);
      check("glitch2_data", 32'(p_data), 32'h5A);

      snap();
      send(8'hFF, 1'b0, 1'b0, 1'b1, 5, 1'b0);
      idle(4);
      check("noise1_dv", n_dv - b_dv, 1);
      check("noise1_data", 32'(p_data), 32'hFF);
      snap();
      send(8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      idle(4);
      check("noise2_dv", n_dv - b_dv, 1);
      check("noise2_data", 32'(p_data), 32'h00);
      snap();
      send(8'h96, 1'b0, 1'b0, 1'b1, 6, 1'b0);
      idle(4);
      check("noise3_dv", n_dv - b_dv, 1);
      check("noise3_data", 32'(p_data), 32'h96);

      snap();
      bit_drv(1'b0, -1);
      for (int i = 0; i < 4; i++) bit_drv(1'b1, -1);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      rst_n = 1'b1;
      idle(10);
      check("abort_dv", n_dv - b_dv, 0);
      check("abort_err", (n_pe - b_pe) + (n_se - b_se), 0);
      check("abort_data", 32'(p_data), 32'h0);

      snap();
      dv_log.delete();
      send(8'h11, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle(4);
      f0 = (dv_log.size() > 0) ? 32'(dv_log[0]) : 32'hxxxxxxxx;
      f1 = (dv_log.size() > 1) ? 32'(dv_log[1]) : 32'hxxxxxxxx;
      check("b2b_dv", n_dv - b_dv, 2);
      check("b2b_first", f0, 32'h11);
      check("b2b_second", f1, 32'h22);
      check("b2b_err", (n_pe - b_pe) + (n_se - b_se), 0);

      par_en = 1'b0;
      snap();
      rx = 1'b0;
      repeat (160) @(negedge clk);
      idle(100);
      check("break_se", n_se - b_se, 2);
      check("break_dv", n_dv - b_dv, 0);
      check("break_pe", n_pe - b_pe, 0);

      check("dv_with_err", n_mix, 0);
      check("dv_width", n_long, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial-to-parallel UART receiver. It is the far-end counterpart of the UART transmitter top (start bit, 8 data bits LSB first, optional parity, one stop bit; line idles high). CLK runs at OVERSAMPLE × baud. The block detects the start bit, samples each bit by majority vote near mid-bit, checks parity and stop bit, and presents the byte with a one-cycle DATA_VALID pulse.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
OVERSAMPLE, 8, CLK cycles per bit period. Must be even and ≥ 4.

Ports:
CLK  input  1  system clock, OVERSAMPLE × baud rate.
RST  input  1  asynchronous, active-low reset.
RX_IN  input  1  serial line; idle = 1.
PAR_EN  input  1  1 = frame carries a parity bit. Sampled at start-bit detection.
PAR_TYP  input  1  0 = even, 1 = odd. Sampled at start-bit detection.
P_DATA  output  DATA_WIDTH  received byte. Holds its value until the next valid frame.
DATA_VALID  output  1  one-cycle pulse when the frame is good.
PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
STP_ERR  output  1  one-cycle pulse when the stop bit samples as 0.

Behaviour:
- Reset (RST=0, async): state IDLE; P_DATA=0; DATA_VALID, PAR_ERR and STP_ERR = 0; all counters = 0.
- Counters:
  - edge_cnt counts 0..OVERSAMPLE-1 within a bit and wraps to 0.
  - bit_cnt increments when edge_cnt wraps.
- Sample points: edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of these 3 samples and is registered at OVERSAMPLE/2+1.
- States:
  - IDLE: when RX_IN=0, go to START with edge_cnt cleared. Latch PAR_EN and PAR_TYP.
  - START: if the majority sample = 1, the start was a glitch; return to IDLE and produce no outputs. Otherwise, at edge_cnt wrap go to DATA.
  - DATA: shift the sample into a shift register LSB first (bit0 received first). After DATA_WIDTH bits, go to PARITY if PAR_EN latched, else STOP.
  - PARITY: compare the sample against the expected parity: XOR of the data, inverted when PAR_TYP=1. A mismatch sets the internal par_fail flag. At wrap go to STOP.
  - STOP: evaluated at the sample point, not at the end of the bit.
    - Sample = 0: STP_ERR.
    - Sample = 1 and par_fail set: PAR_ERR only.
    - Otherwise: P_DATA ← shift register and DATA_VALID.
    - Return to IDLE at the same cycle, so the next start edge can arrive half a bit early.
- Latency: the pulse occurs 1 CLK after the stop-bit decision sample (edge_cnt = OVERSAMPLE/2+1 of the stop bit).
- Error priority: STP_ERR and PAR_ERR may pulse together. DATA_VALID is never asserted with either error.
- Error frames leave P_DATA unchanged.
- PAR_EN and PAR_TYP changes mid-frame are ignored.
- A break (RX_IN held at 0) gives STP_ERR, then a new start detected immediately in IDLE. It then repeats STP_ERR per frame time until the line returns high.
- Reset mid-frame aborts the frame with no pulse.

Optional Feature:
Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before all logic. Every output latency grows by +2 CLK.
- Undefined: RX_IN is used directly; RX_IN must already be synchronous to CLK.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - PAR_EVEN=0 and PAR_ODD=1.
  - default DATA_WIDTH and OVERSAMPLE constants.
- One sub-module, uart_rx_bit_timer:
  - holds edge_cnt and bit_cnt.
  - does the 3-sample majority voting.
  - produces the sample_done and bit_done strobes consumed by the FSM.

Test Plan:
- Basic frame: PAR_EN=0, send 0xA5 → P_DATA=0xA5, DATA_VALID high exactly 1 CLK. PAR_ERR and STP_ERR stay 0.
- Even parity: PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → DATA_VALID. Resend 0x3C with parity 1 → PAR_ERR pulse, P_DATA stays 0x3C from before, no DATA_VALID.
- Stop error: odd parity, send 0x01 with correct parity bit 0 but stop=0 → STP_ERR pulse, no DATA_VALID.
- Glitch: RX_IN low for 2 CLK (OVERSAMPLE=8), then high → returns to IDLE, no pulses. Then 0x5A sent → received correctly.
- Noise: one sample-point cycle inverted in each data bit of 0xFF → still 0xFF with DATA_VALID (majority vote).
- Reset mid-frame: assert RST during bit 4, release, send back-to-back 0x11 and 0x22 with no idle gap → two DATA_VALID pulses with 0x11 then 0x22, no errors.
